// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input and a registered bit stream.
// Define SER_PARITY_EN to append one even-parity bit after the LSB of each frame.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             x_nx, last_nx;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par, par_nx;
`endif

  // A new word may land in the same cycle the previous frame emits its last bit.
  assign in_ready = reset && ((state == IDLE) || x_last);
  assign accept   = in_valid && in_ready;

  // x_valid and busy come straight off the state flop, so they stay glitch-free.
  assign x_valid  = (state == SHIFT);
  assign busy     = (state == SHIFT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    x_nx     = x;
    last_nx  = x_last;
`ifdef SER_PARITY_EN
    par_nx   = par;
`endif
    if (accept) begin
      state_nx = SHIFT;
      x_nx     = in_data[WIDTH-1];
      shreg_nx = {in_data[WIDTH-2:0], 1'b0};
      cnt_nx   = CW'(FRAME - 1);
      last_nx  = 1'b0;
`ifdef SER_PARITY_EN
      par_nx   = ^in_data;
`endif
    end else if (state == SHIFT) begin
      if (x_last) begin
        state_nx = IDLE;
        x_nx     = 1'b0;
        last_nx  = 1'b0;
        shreg_nx = '0;
        cnt_nx   = '0;
      end else begin
        // cnt counts bits still to come after the one on x now.
        cnt_nx   = cnt - CW'(1);
        last_nx  = (cnt == CW'(1));
        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
`ifdef SER_PARITY_EN
        x_nx     = (cnt == CW'(1)) ? par : shreg[WIDTH-1];
`else
        x_nx     = shreg[WIDTH-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      x      <= 1'b0;
      x_last <= 1'b0;
`ifdef SER_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      x      <= x_nx;
      x_last <= last_nx;
`ifdef SER_PARITY_EN
      par    <= par_nx;
`endif
    end
  end

endmodule
